dec_unbinder_seq: RTL and testbench

Sequential unbinder for the sparse-HDC datapath, the inverse of the encoder binder packs. The encoder binds each feature by rotating its level HV left by a per-feature constant from the shared shift table. This block captures one bound HV and streams out, one feature per beat, the HV rotated right by that feature's shift, which recovers the level-HV candidate for that feature. It sits between the associative/query stage and the per-feature level decoders and uses a valid/ready output stream.

---
 rtl/dec_unbinder_seq_pkg.sv | 22 ++
 rtl/dec_unbinder_seq_if.sv | 28 ++
 rtl/dec_unbinder_seq_rotr.sv | 25 ++
 rtl/dec_unbinder_seq.sv | 112 +++++++++++
 tb/tb_dec_unbinder_seq.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/dec_unbinder_seq_pkg.sv
// Shared HDC constants for the unbinder: dimensions, the packed per-feature
// shift table and the unbinder state encoding.
package dec_unbinder_seq_pkg;

    localparam int HV_DIM          = 1024;
    localparam int FEATURES_PER_CC = 8;
    localparam int SHIFT_W         = 10;
    localparam int N_SHIFTS        = 16;

    // Entry k lives at [k*SHIFT_W +: SHIFT_W]; written most-significant entry first.
    localparam logic [N_SHIFTS*SHIFT_W-1:0] SHIFTS = {
        10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd0,   10'd4,   10'd1,
        10'd1023, 10'd511, 10'd100, 10'd64,  10'd7,   10'd3,   10'd1,   10'd0
    };

    typedef enum logic {IDLE, RUN} dec_unbind_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dec_unbinder_seq_if.sv
// Capture request and unbound-beat stream between the query stage and the level decoders.
interface dec_unbinder_seq_if
    import dec_unbinder_seq_pkg::*;
#(
    parameter int HV_DIM = dec_unbinder_seq_pkg::HV_DIM,
    parameter int IDX_W  = idx_w(dec_unbinder_seq_pkg::FEATURES_PER_CC)
);
    logic              start_decoding;
    logic              en;
    logic [HV_DIM-1:0] bound_hv;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [HV_DIM-1:0] unbound_hv;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              done;

    modport master (
        output start_decoding, en, bound_hv, out_ready,
        input  busy, out_valid, unbound_hv, out_idx, out_last, done
    );

    modport slave (
        input  start_decoding, en, bound_hv, out_ready,
        output busy, out_valid, unbound_hv, out_idx, out_last, done
    );
endinterface

// File: rtl/dec_unbinder_seq_rotr.sv
// Combinational log2(HV_DIM)-stage barrel right-rotator; out[j] = in[(j+s) mod HV_DIM].
module dec_rotr #(
    parameter int HV_DIM  = 1024,
    parameter int SHIFT_W = 10
) (
    input  logic [HV_DIM-1:0]  hv_in,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [HV_DIM-1:0]  hv_out
);
    localparam int RW = (HV_DIM > 1) ? $clog2(HV_DIM) : 1;

    logic [RW-1:0]             sh;
    logic [RW:0][HV_DIM-1:0]   stg;

    // Reduced amount is < HV_DIM, so summing the power-of-two stages stays exact.
    assign sh     = RW'(32'(shamt) % HV_DIM);
    assign stg[0] = hv_in;

    for (genvar k = 0; k < RW; k++) begin : g_stage
        localparam int AMT = (1 << k) % HV_DIM;
        assign stg[k+1] = sh[k] ? ((stg[k] >> AMT) | (stg[k] << (HV_DIM - AMT))) : stg[k];
    end

    assign hv_out = stg[RW];
endmodule

// File: rtl/dec_unbinder_seq.sv
// Sequential unbinder: captures one bound HV and streams one right-rotated beat per feature.
module dec_unbinder_seq
    import dec_unbinder_seq_pkg::*;
#(
    parameter int HV_DIM          = dec_unbinder_seq_pkg::HV_DIM,
    parameter int FEATURES_PER_CC = dec_unbinder_seq_pkg::FEATURES_PER_CC,
    parameter int SHIFT_BASE      = 0,
    parameter int IDX_W           = idx_w(FEATURES_PER_CC)
) (
    input  logic               clk,
    input  logic               nrst,
    dec_unbinder_seq_if.slave  bus
);
    dec_unbind_state_t state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HV_DIM-1:0] hv_q, hv_d;
    logic [HV_DIM-1:0] uhv_q, uhv_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_q, last_d;
    logic              load;
    logic [HV_DIM-1:0] rot_src;
    logic [HV_DIM-1:0] rot_out;
    logic [SHIFT_W-1:0] shamt;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hv_d    = hv_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        last_d  = last_q;
        load    = 1'b0;
        rot_src = hv_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_decoding && bus.en) begin
                    hv_d    = bus.bound_hv;
                    rot_src = bus.bound_hv;
                    idx_d   = '0;
                    load    = 1'b1;
                    vld_d   = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = (FEATURES_PER_CC == 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (vld_q && bus.out_ready) begin
                    if (last_q) begin
                        vld_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        load   = 1'b1;
                        last_d = ((idx_q + 1'b1) == IDX_W'(FEATURES_PER_CC - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The table is a constant, so the index simply selects among wired constants.
    always_comb begin
        shamt = '0;
        for (int i = 0; i < FEATURES_PER_CC; i++)
            if (idx_d == IDX_W'(i)) shamt = SHIFTS[(SHIFT_BASE + i)*SHIFT_W +: SHIFT_W];
    end

    dec_rotr #(.HV_DIM(HV_DIM), .SHIFT_W(SHIFT_W)) u_rotr (
        .hv_in  (rot_src),
        .shamt  (shamt),
        .hv_out (rot_out)
    );

    assign uhv_d = load ? rot_out : uhv_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hv_q    <= '0;
            uhv_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hv_q    <= hv_d;
            uhv_q   <= uhv_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.out_valid  = vld_q;
    assign bus.unbound_hv = uhv_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_last   = last_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_dec_unbinder_seq.sv
// Directed bench: small 16-bit instance for stream/control cases, full-width instance for round trips.
module tb_dec_unbinder_seq;
    import dec_unbinder_seq_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dec_unbinder_seq_if #(.HV_DIM(16), .IDX_W(2))   ifa ();
    dec_unbinder_seq_if #(.HV_DIM(1024), .IDX_W(3)) ifb ();

    dec_unbinder_seq #(.HV_DIM(16), .FEATURES_PER_CC(3), .SHIFT_BASE(8), .IDX_W(2)) u_a (
        .clk(clk), .nrst(nrst), .bus(ifa));
    dec_unbinder_seq #(.HV_DIM(1024), .FEATURES_PER_CC(8), .SHIFT_BASE(0), .IDX_W(3)) u_b (
        .clk(clk), .nrst(nrst), .bus(ifb));

    task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Encoder-side binder: left rotate, out[(j+s) mod N] = in[j].
    function automatic logic [1023:0] bind_rotl(input logic [1023:0] x, input int s);
        logic [1023:0] r;
        r = '0;
        for (int j = 0; j < 1024; j++) r[(j + s) % 1024] = x[j];
        return r;
    endfunction

    task automatic chk_a(input string tag, input logic v, input logic [1:0] idx,
                         input logic [15:0] hv, input logic last);
        chk({tag, ".valid"}, 1024'(ifa.out_valid), 1024'(v));
        chk({tag, ".idx"},   1024'(ifa.out_idx),   1024'(idx));
        chk({tag, ".hv"},    1024'(ifa.unbound_hv), 1024'(hv));
        chk({tag, ".last"},  1024'(ifa.out_last),  1024'(last));
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, ".valid"}, 1024'(ifa.out_valid), 1024'(0));
        chk({tag, ".busy"},  1024'(ifa.busy),      1024'(0));
        chk({tag, ".done"},  1024'(ifa.done),      1024'(0));
        chk({tag, ".last"},  1024'(ifa.out_last),  1024'(0));
        chk({tag, ".idx"},   1024'(ifa.out_idx),   1024'(0));
        chk({tag, ".hv"},    1024'(ifa.unbound_hv), 1024'(0));
    endtask

    initial begin
        logic [1023:0] bv;
        int s;
        bit seen;
        ifa.start_decoding = 0; ifa.en = 0; ifa.bound_hv = '0; ifa.out_ready = 1;
        ifb.start_decoding = 0; ifb.en = 0; ifb.bound_hv = '0; ifb.out_ready = 1;
        #3;
        chk_reset_a("rst");
        tick(); tick();
        nrst = 1;

        // start without en
        ifa.start_decoding = 1; ifa.en = 0; ifa.bound_hv = 16'hABCD;
        tick();
        chk("qual.busy", 1024'(ifa.busy), 1024'(0));
        chk("qual.valid", 1024'(ifa.out_valid), 1024'(0));

        // basic stream, shifts {1,4,0}
        ifa.en = 1; ifa.bound_hv = 16'h0001;
        tick();
        ifa.start_decoding = 0;
        chk_a("b0", 1, 0, 16'h8000, 0);
        chk("b0.busy", 1024'(ifa.busy), 1024'(1));
        tick(); chk_a("b1", 1, 1, 16'h1000, 0);
        tick(); chk_a("b2", 1, 2, 16'h0001, 1);
        tick();
        chk("b.done", 1024'(ifa.done), 1024'(1));
        chk("b.busy", 1024'(ifa.busy), 1024'(0));
        chk("b.valid", 1024'(ifa.out_valid), 1024'(0));
        tick();
        chk("b.done_once", 1024'(ifa.done), 1024'(0));

        // second start during RUN is ignored; backpressure on idx1
        ifa.start_decoding = 1; ifa.bound_hv = 16'h00F0;
        tick();
        chk_a("w0", 1, 0, 16'h0078, 0);
        ifa.bound_hv = 16'hFFFF;
        tick();
        chk_a("w1", 1, 1, 16'h000F, 0);
        ifa.start_decoding = 0; ifa.out_ready = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_a($sformatf("bp%0d", c), 1, 1, 16'h000F, 0);
        end
        ifa.out_ready = 1;
        tick();
        chk_a("w2", 1, 2, 16'h00F0, 1);
        tick();
        chk("w.done", 1024'(ifa.done), 1024'(1));

        // start in the done cycle runs back-to-back
        ifa.start_decoding = 1; ifa.bound_hv = 16'h0003;
        tick();
        ifa.start_decoding = 0;
        chk_a("bb0", 1, 0, 16'h8001, 0);
        tick();
        chk_a("bb1", 1, 1, 16'h3000, 0);

        // asynchronous reset mid-stream
        #2 nrst = 0;
        #1 chk_reset_a("mrst");
        tick();
        chk_reset_a("mrst_hold");
        nrst = 1;
        tick();
        chk("mrst.nodone", 1024'(ifa.done), 1024'(0));
        chk("mrst.novalid", 1024'(ifa.out_valid), 1024'(0));
        ifa.start_decoding = 1; ifa.bound_hv = 16'h0010;
        tick();
        ifa.start_decoding = 0;
        chk_a("r0", 1, 0, 16'h0008, 0);
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (ifa.done) seen = 1;
        end
        chk("r.done_seen", 1024'(seen), 1024'(1));

        // round trip at full width: rebinding each beat must give back the bound HV
        for (int v = 0; v < 50; v++) begin
            for (int w = 0; w < 32; w++) bv[w*32 +: 32] = $urandom;
            ifb.bound_hv = bv; ifb.start_decoding = 1; ifb.en = 1;
            tick();
            ifb.start_decoding = 0;
            for (int i = 0; i < 8; i++) begin
                s = int'(SHIFTS[i*SHIFT_W +: SHIFT_W]);
                if (v == 0) begin
                    chk($sformatf("rt.idx%0d", i), 1024'(ifb.out_idx), 1024'(i));
                    chk($sformatf("rt.last%0d", i), 1024'(ifb.out_last), 1024'(i == 7));
                end
                chk($sformatf("rt%0d.%0d", v, i), bind_rotl(ifb.unbound_hv, s), bv);
                tick();
            end
            chk($sformatf("rt%0d.done", v), 1024'(ifb.done), 1024'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
